float_mul_pipe: RTL and testbench
=================================

FLOAT_MUL_PIPE -- requirements
Module: float_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, SHALL set the exponent field width.
REQ-002 Parameter MAN_W, default 23, SHALL set the stored mantissa field width; the word width is W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL qualify operands a and b.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an operand pair this cycle.
REQ-007 a, b  input  W  SHALL be the IEEE-754-style operands (sign | exponent | mantissa).
REQ-008 out_valid  output  1  SHALL qualify result and flags.
REQ-009 out_ready  input  1  SHALL indicate downstream accepts the result this cycle.
REQ-010 result  output  W  SHALL be the product.
REQ-011 flags  output  4  SHALL be {invalid, overflow, underflow, inexact}, valid with out_valid.

Function
REQ-012 The block SHALL be a 3-stage pipeline: S1 classify and mantissa multiply; S2 normalise and exponent adjust; S3 round, pack and register the output.
REQ-013 Latency SHALL be exactly 3 cycles from the in_valid&in_ready handshake to out_valid when out_ready is held high; throughput SHALL be 1 result per cycle.
REQ-014 A stall SHALL be defined as out_valid & ~out_ready; during a stall every stage SHALL hold, in_ready SHALL be 0, and result/flags SHALL stay stable.
REQ-015 in_ready SHALL equal ~stall; empty pipeline slots SHALL carry valid=0 bubbles, and bubbles SHALL NOT be compressed.
REQ-016 The result sign SHALL be sign(a) XOR sign(b) for all non-NaN results.
REQ-017 Subnormal inputs SHALL be treated as signed zero (denormals-are-zero).
REQ-018 A NaN operand, or Inf times zero, SHALL give the canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1, other bits 0); Inf times zero SHALL also set invalid, and a signalling NaN input (mantissa MSB 0, non-zero) SHALL set invalid.
REQ-019 Inf times a finite non-zero value, or Inf times Inf, SHALL give a signed Inf with no flags set.
REQ-020 The biased exponent SHALL be computed as ea+eb-bias in EXP_W+2 signed bits, where bias = 2^(EXP_W-1)-1.
REQ-021 The mantissa product (2*(MAN_W+1) bits) SHALL be normalised by at most a 1-bit right shift, with the exponent incremented on that shift.
REQ-022 Rounding SHALL be round-to-nearest-even using guard and sticky bits; a rounding carry SHALL renormalise and increment the exponent.
REQ-023 inexact SHALL be set when any discarded bit is non-zero.
REQ-024 A final exponent at or above the all-ones value SHALL give a signed Inf with overflow and inexact set.
REQ-025 A final exponent at or below 0 SHALL give a signed zero with underflow set, plus inexact when the product was non-zero (flush-to-zero).
REQ-026 An exact zero product SHALL give a signed zero with no flags set.

Reset
REQ-027 While rst_n=0 at a clock edge, all stage valids, out_valid, result and flags SHALL clear to 0 and in_ready SHALL read 1 on the following cycle.
REQ-028 Operations in flight when reset asserts SHALL be discarded, with no partial output.

Structure
REQ-029 The package float_pkg SHALL hold the class enum (ZERO, NORMAL, INF, QNAN, SNAN), the flag-index constants, and the bias and canonical-NaN constant functions of EXP_W/MAN_W.
REQ-030 Operand decoding SHALL be one sub-module, float_classify, instantiated once per operand in S1.

Verification (default parameters)
REQ-031 a=0x3F800000, b=0x40000000, out_ready=1 -> result 0x40000000 with flags 0 exactly 3 cycles later.
REQ-032 a=0xBFC00000, b=0x3F000000 -> result 0xBF400000, flags 0.
REQ-033 a=0x7F800000, b=0x00000000 -> result 0x7FC00000, invalid=1; a=0x7FC00000, b=0x3F800000 -> 0x7FC00000, flags 0.
REQ-034 a=0x7F7FFFFF, b=0x40000000 -> result 0x7F800000 with overflow=1 and inexact=1; a=0x00800000, b=0x00800000 -> 0x00000000 with underflow=1 and inexact=1.
REQ-035 a=b=0x3F800001 -> result 0x3F800002, inexact=1 (rounding).
REQ-036 Stream 6 back-to-back pairs with out_ready low for 4 cycles mid-stream -> in_ready drops, no result is lost or duplicated, order is preserved; asserting rst_n=0 mid-stream -> out_valid=0 on the next cycle.

Source files
------------

// File: rtl/float_pkg.sv
// Shared types and constants for the pipelined floating-point multiplier.
// The helper functions size NaN and bias from the field widths.
package float_pkg;

    typedef enum logic [2:0] {
        Zero,
        Normal,
        Inf,
        Qnan,
        Snan
    } float_class_e;

    // Result category decided in S1 and carried down the pipe
    typedef enum logic [1:0] {
        KindNum,
        KindZero,
        KindInf,
        KindNan
    } res_kind_e;

    localparam int unsigned FlagInvalid   = 3;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagInexact   = 0;

    localparam int unsigned MaxWordW = 128;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set; caller truncates to word width
    function automatic logic [MaxWordW-1:0] qnan_word(input int unsigned exp_w,
                                                      input int unsigned man_w);
        logic [MaxWordW-1:0] w;
        w = ((MaxWordW'(1) << exp_w) - MaxWordW'(1)) << man_w;
        w = w | (MaxWordW'(1) << (man_w - 1));
        return w;
    endfunction

endpackage

// File: rtl/float_classify.sv
// Decodes one operand into sign, exponent, significand with hidden bit, and class.
// Subnormals are reported as Zero (denormals-are-zero).
module float_classify
    import float_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       sig_o,
    output float_class_e         cls_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    always_comb begin
        exp_f  = op_i[MAN_W +: EXP_W];
        man_f  = op_i[MAN_W-1:0];
        sign_o = op_i[EXP_W+MAN_W];
        exp_o  = exp_f;
        if (exp_f == '0) begin
            cls_o = Zero;
        end else if (&exp_f) begin
            if (man_f == '0) begin
                cls_o = Inf;
            end else if (man_f[MAN_W-1]) begin
                cls_o = Qnan;
            end else begin
                cls_o = Snan;
            end
        end else begin
            cls_o = Normal;
        end
        sig_o = (cls_o == Normal) ? {1'b1, man_f} : '0;
    end

endmodule

// File: rtl/float_mul_pipe.sv
// Three-stage floating-point multiplier: S1 classify/multiply, S2 normalise,
// S3 round/pack. The whole pipe freezes while the output is stalled.
module float_mul_pipe
    import float_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned EW = EXP_W + 2;

    localparam logic signed [EW-1:0] BiasE   = EW'(exp_bias(EXP_W));
    localparam logic signed [EW-1:0] MaxExpE = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZeroE   = '0;
    localparam logic [W-1:0]         QNanWord = W'(qnan_word(EXP_W, MAN_W));

    logic stall;
    logic advance;

    // S1 operand decode
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [SW-1:0]    sig_a, sig_b;
    float_class_e     cls_a, cls_b;

    float_classify #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_cls_a (
        .op_i  (a),
        .sign_o(sign_a),
        .exp_o (exp_a),
        .sig_o (sig_a),
        .cls_o (cls_a)
    );

    float_classify #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_cls_b (
        .op_i  (b),
        .sign_o(sign_b),
        .exp_o (exp_b),
        .sig_o (sig_b),
        .cls_o (cls_b)
    );

    logic                 s1_valid_q;
    logic                 s1_sign_d, s1_sign_q;
    logic signed [EW-1:0] s1_exp_d, s1_exp_q;
    logic [PW-1:0]        s1_prod_d, s1_prod_q;
    res_kind_e            s1_kind_d, s1_kind_q;
    logic                 s1_invalid_d, s1_invalid_q;

    logic                 s2_valid_q;
    logic                 s2_sign_q;
    logic signed [EW-1:0] s2_exp_d, s2_exp_q;
    logic [PW-2:0]        s2_man_d, s2_man_q;
    logic                 s2_sticky_d, s2_sticky_q;
    res_kind_e            s2_kind_q;
    logic                 s2_invalid_q;

    logic                 out_valid_q;
    logic [W-1:0]         result_d, result_q;
    logic [3:0]           flags_d, flags_q;

    assign stall    = out_valid_q & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    logic any_nan;
    logic inf_zero;

    always_comb begin
        s1_sign_d = sign_a ^ sign_b;
        s1_exp_d  = EW'(exp_a) + EW'(exp_b) - BiasE;
        s1_prod_d = PW'(sig_a) * PW'(sig_b);
        any_nan   = (cls_a == Qnan) || (cls_a == Snan) || (cls_b == Qnan) || (cls_b == Snan);
        inf_zero  = ((cls_a == Inf) && (cls_b == Zero)) || ((cls_a == Zero) && (cls_b == Inf));
        s1_invalid_d = (cls_a == Snan) || (cls_b == Snan) || inf_zero;
        if (any_nan || inf_zero) begin
            s1_kind_d = KindNan;
        end else if ((cls_a == Inf) || (cls_b == Inf)) begin
            s1_kind_d = KindInf;
        end else if ((cls_a == Zero) || (cls_b == Zero)) begin
            s1_kind_d = KindZero;
        end else begin
            s1_kind_d = KindNum;
        end
    end

    // Product lies in [1,4): at most one right shift puts the leading one at PW-2
    logic prod_top;

    always_comb begin
        prod_top    = s1_prod_q[PW-1];
        s2_man_d    = prod_top ? s1_prod_q[PW-1:1] : s1_prod_q[PW-2:0];
        s2_sticky_d = prod_top & s1_prod_q[0];
        s2_exp_d    = s1_exp_q + EW'(prod_top);
    end

    logic [SW-1:0]        kept;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [SW:0]          rounded;
    logic                 carry;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] exp_r;
    logic                 inexact;

    always_comb begin
        kept     = s2_man_q[PW-2:MAN_W];
        guard    = s2_man_q[MAN_W-1];
        sticky   = (|s2_man_q[MAN_W-2:0]) | s2_sticky_q;
        round_up = guard & (sticky | kept[0]);
        rounded  = {1'b0, kept} + (SW+1)'(round_up);
        carry    = rounded[SW];
        frac     = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        exp_r    = s2_exp_q + EW'(carry);
        inexact  = guard | sticky;

        result_d = '0;
        flags_d  = '0;
        case (s2_kind_q)
            KindNan: begin
                result_d             = QNanWord;
                flags_d[FlagInvalid] = s2_invalid_q;
            end
            KindInf: begin
                result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            KindZero: begin
                result_d = {s2_sign_q, {(W-1){1'b0}}};
            end
            default: begin
                if (exp_r >= MaxExpE) begin
                    result_d              = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d[FlagOverflow] = 1'b1;
                    flags_d[FlagInexact]  = 1'b1;
                end else if (exp_r <= ZeroE) begin
                    // Flush to zero; a normal-times-normal product is never exactly zero
                    result_d               = {s2_sign_q, {(W-1){1'b0}}};
                    flags_d[FlagUnderflow] = 1'b1;
                    flags_d[FlagInexact]   = 1'b1;
                end else begin
                    result_d             = {s2_sign_q, exp_r[EXP_W-1:0], frac};
                    flags_d[FlagInexact] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_prod_q    <= '0;
            s1_kind_q    <= KindZero;
            s1_invalid_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_exp_q     <= '0;
            s2_man_q     <= '0;
            s2_sticky_q  <= 1'b0;
            s2_kind_q    <= KindZero;
            s2_invalid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
        end else if (advance) begin
            s1_valid_q   <= in_valid;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_prod_q    <= s1_prod_d;
            s1_kind_q    <= s1_kind_d;
            s1_invalid_q <= s1_invalid_d;
            s2_valid_q   <= s1_valid_q;
            s2_sign_q    <= s1_sign_q;
            s2_exp_q     <= s2_exp_d;
            s2_man_q     <= s2_man_d;
            s2_sticky_q  <= s2_sticky_d;
            s2_kind_q    <= s1_kind_q;
            s2_invalid_q <= s1_invalid_q;
            out_valid_q  <= s2_valid_q;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed bench for float_mul_pipe: single-shot vectors with latency checks,
// a stalled back-to-back stream, and a mid-stream reset.
module tb_float_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks;
    int n_fail;

    float_mul_pipe #(
        .EXP_W(8),
        .MAN_W(23)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    localparam int NV = 12;
    // flags = {invalid, overflow, underflow, inexact}
    logic [31:0] va [NV] = '{32'h3F800000, 32'hBFC00000, 32'h7F800000, 32'h7FC00000,
                             32'h7F7FFFFF, 32'h00800000, 32'h3F800001, 32'h3FC00000,
                             32'h3F800001, 32'h80000000, 32'h7F800000, 32'h7F800001};
    logic [31:0] vb [NV] = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h3F800000,
                             32'h40000000, 32'h00800000, 32'h3F800001, 32'h3FC00000,
                             32'h3FC00000, 32'h3F800000, 32'hC0000000, 32'h3F800000};
    logic [31:0] vr [NV] = '{32'h40000000, 32'hBF400000, 32'h7FC00000, 32'h7FC00000,
                             32'h7F800000, 32'h00000000, 32'h3F800002, 32'h40100000,
                             32'h3FC00002, 32'h80000000, 32'hFF800000, 32'h7FC00000};
    logic [3:0]  vf [NV] = '{4'h0, 4'h0, 4'h8, 4'h0,
                             4'h5, 4'h3, 4'h1, 4'h0,
                             4'h1, 4'h0, 4'h0, 4'h8};

    logic [31:0] sa [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] sr [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                            32'h41000000, 32'h41200000, 32'h41400000};

    task automatic run_one(input int idx);
        int lat;
        bit got;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = va[idx];
        b         = vb[idx];
        #1;
        check_eq($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 10 && !got) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        check_eq($sformatf("vec%0d_seen", idx), 64'(got), 64'd1);
        check_eq($sformatf("vec%0d_latency", idx), 64'(lat), 64'd3);
        check_eq($sformatf("vec%0d_result", idx), 64'(result), 64'(vr[idx]));
        check_eq($sformatf("vec%0d_flags", idx), 64'(flags), 64'(vf[idx]));
    endtask

    initial begin
        int tx;
        int rx;
        bit saw_stall;
        bit prev_stall;
        logic [31:0] held;
        bit extra;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_result", 64'(result), 64'd0);
        check_eq("reset_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_one(i);

        // Back-to-back stream with a 4-cycle output stall
        tx = 0;
        rx = 0;
        saw_stall = 1'b0;
        prev_stall = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 8);
            if (tx < 6) begin
                in_valid = 1'b1;
                a        = sa[tx];
                b        = 32'h40000000;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                check_eq($sformatf("stream%0d_result", rx), 64'(result), 64'(sr[rx]));
                check_eq($sformatf("stream%0d_flags", rx), 64'(flags), 64'd0);
                rx++;
            end
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", 64'(in_ready), 64'd0);
                if (prev_stall) check_eq("stall_result_hold", 64'(result), 64'(held));
                held = result;
                saw_stall = 1'b1;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (in_valid && in_ready) tx++;
        end
        check_eq("stream_count", 64'(rx), 64'd6);
        check_eq("stream_saw_stall", 64'(saw_stall), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        check_eq("stream_no_duplicate", 64'(extra), 64'd0);

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = sa[k];
            b        = 32'h40000000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check_eq("midreset_out_valid", 64'(out_valid), 64'd0);
        check_eq("midreset_in_ready", 64'(in_ready), 64'd1);
        check_eq("midreset_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        check_eq("midreset_no_partial", 64'(extra), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
